// File: rtl/csa_mp_seq_if.sv
// Requester-side bundle for the multi-precision add/sub sequencer.
// Operands and sub are sampled on start; result and cout are valid with done.
interface csa_mp_seq_if #(
  parameter int WORDS = 4,
  parameter int W     = 64
);
  logic               start;
  logic               sub;
  logic [WORDS*W-1:0] a_in;
  logic [WORDS*W-1:0] b_in;
  logic               busy;
  logic               done;
  logic [WORDS*W-1:0] result;
  logic               cout;

  modport master (
    output start, sub, a_in, b_in,
    input  busy, done, result, cout
  );

  modport slave (
    input  start, sub, a_in, b_in,
    output busy, done, result, cout
  );
endinterface

// File: rtl/csa_mp_seq.sv
// Multi-precision add/sub sequencer: feeds one limb per cycle, LSB first,
// through an external 64-bit carry-select adder and assembles the result.
module csa_mp_seq #(
  parameter int WORDS = 4,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rst,
  csa_mp_seq_if.slave  bus,
  output logic [W-1:0] add_x,
  output logic [W-1:0] add_y,
  output logic [W-1:0] add_cin,
  input  logic [W-1:0] add_sum,
  input  logic         add_cout
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int N  = WORDS * W;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [N-1:0]  a_reg;
  logic [N-1:0]  b_reg;
  logic [N-1:0]  res_q;
  logic [IW-1:0] idx;
  logic          busy_q;
  logic          done_q;
  logic          cout_q;

  logic [N-1:0]  b_eff;
  logic [IW-1:0] nidx;
  logic          last;

  assign b_eff = bus.sub ? ~bus.b_in : bus.b_in;
  assign nidx  = idx + 1'b1;
  assign last  = (idx == IW'(WORDS - 1));

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = res_q;
  assign bus.cout   = cout_q;

  // The csa operands are registered one edge ahead: the edge that
  // consumes limb idx also loads limb idx+1 and its carry-in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      res_q   <= '0;
      idx     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      add_x   <= '0;
      add_y   <= '0;
      add_cin <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_reg   <= bus.a_in;
            b_reg   <= b_eff;
            idx     <= '0;
            res_q   <= '0;
            busy_q  <= 1'b1;
            add_x   <= bus.a_in[W-1:0];
            add_y   <= b_eff[W-1:0];
            add_cin <= {{(W-1){1'b0}}, bus.sub};
            state   <= RUN;
          end
        end
        RUN: begin
          res_q[idx*W +: W] <= add_sum;
          if (last) begin
            cout_q  <= add_cout;
            done_q  <= 1'b1;
            add_x   <= '0;
            add_y   <= '0;
            add_cin <= '0;
            state   <= DONE;
          end else begin
            idx     <= nidx;
            add_x   <= a_reg[nidx*W +: W];
            add_y   <= b_reg[nidx*W +: W];
            add_cin <= {{(W-1){1'b0}}, add_cout};
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/csa_mp_seq.md
Name: csa_mp_seq

Overview:
- Multi-precision add/subtract sequencer that drives the shared 64-bit carry-select adder (csa) one limb per cycle.
- Latches two WORDS×64-bit operands on start and feeds limbs LSB-first through the external combinational csa. Propagates the carry between limbs and assembles the wide result.
- Sits between the wide-arithmetic requester and the csa instance. Owns all csa inputs.

Parameters:
- WORDS, 4: number of 64-bit limbs per operand; ≥2.
- W, 64: limb width; fixed to csa width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- sub  input  1  sampled with start; 1 = a_in − b_in, 0 = a_in + b_in.
- a_in  input  WORDS*W  operand A, limb 0 = bits [63:0].
- b_in  input  WORDS*W  operand B.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse, result/cout valid.
- result  output  WORDS*W  assembled sum/difference; held until next accepted start.
- cout  output  1  final carry (add) or no-borrow flag (sub: 1 when A≥B unsigned).
- add_x  output  W  csa x operand.
- add_y  output  W  csa y operand.
- add_cin  output  W  csa cin; bit0 = carry, bits [63:1] always 0.
- add_sum  input  W  csa sum (combinational from add_x/add_y/add_cin).
- add_cout  input  1  csa carry out.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, busy=0, done=0, result=0, cout=0, add_x=0, add_y=0, add_cin=0; internal a_reg/b_reg/carry/idx cleared.
- rst overrides everything, including mid-RUN: the in-flight operation is discarded and result cleared.
- States are IDLE, RUN and DONE.
- IDLE:
  - csa inputs driven 0.
  - On start=1: a_reg<=a_in; b_reg<=sub ? ~b_in : b_in; carry<=sub; idx<=0; result<=0; go to RUN.
- RUN:
  - add_x = a_reg limb idx; add_y = b_reg limb idx; add_cin = {63'b0, carry}.
  - Each edge: result limb idx <= add_sum; carry <= add_cout; idx <= idx+1.
  - When idx==WORDS-1: cout <= add_cout; go to DONE.
  - Exactly WORDS cycles in RUN.
- DONE:
  - done=1 for exactly one cycle, busy=1.
  - csa inputs driven 0.
  - Next state is IDLE.
- Latency: start accepted at edge N; done high in the cycle after edge N+WORDS, i.e. WORDS+1 cycles after the start cycle.
- start while busy (RUN or DONE) is ignored; no queueing. Back-to-back throughput: one op per WORDS+2 cycles.
- Operands: a_in, b_in and sub are sampled only at the accepting edge. Later changes have no effect.
- idx width: clog2(WORDS). No wrap past WORDS-1.
- Arithmetic is unsigned modulo 2^(WORDS*64). Subtract uses two's complement (invert B, carry-in 1). cout has no overflow meaning for signed interpretation.
- result limbs not yet written in RUN read 0. result is stable from DONE until the next accepted start.

Test Plan (WORDS=4):
- Reset: assert rst 2 cycles with start=1 → busy=0, done=0, result=0, cout=0, add_x/add_y/add_cin=0. No op started after release without a new start.
- Full carry ripple: A=2^256−1, B=1, sub=0 → result=0, cout=1. done high exactly 5 cycles after the start cycle. add_cin bit0 = 0,1,1,1 across the RUN cycles.
- Pattern add: every limb of A and B = 0xAAAAAAAAAAAAAAAA, sub=0 → limb0=0x5555555555555554, limbs1–3=0x5555555555555555, cout=1.
- Subtract: A=7, B=5, sub=1 → result=2, cout=1. A=5, B=7, sub=1 → result=2^256−2 (limbs1–3 all F, limb0=0xFFFFFFFFFFFFFFFE), cout=0.
- Ignored start: pulse start with new operands in each RUN cycle and in DONE → first result unaffected, exactly one done pulse. Start in the following IDLE cycle is accepted.
- Reset mid-op: assert rst in the 2nd RUN cycle → next cycle busy=0, result=0, done never pulses. A subsequent op (A=1, B=2) → result=3, cout=0.
